// File: rtl/svm_pkg.sv
// Shared types and helpers for the SVM classification sequencer.
package svm_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } seq_state_t;

    // Per-beat datapath markers, registered together so they move as one bundle.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic vstart;
        logic vend;
    } marker_t;

    // Counter/address width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/svm_sequencer_delay_line.sv
// Fixed-depth shift register carrying a data word and its valid tag.
module delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = data_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/svm_sequencer.sv
// Sequencer for one SVM classification pass: load test vector, stream NUM_SV
// support vectors with markers, align alpha to kernel latency, return label.
// Optional SVM_SEQ_PERF_EN adds a saturating perf_cycles counter port.
//
//   state  | meaning
//   IDLE   | accepting test elements into the local buffer
//   RUN    | issuing one support-vector element per cycle
//   DRAIN  | all elements issued, waiting for the datapath label
//   RESULT | label held on res_* until consumed
module svm_sequencer
    import svm_pkg::*;
#(
    parameter int DIM        = 8,
    parameter int NUM_SV     = 16,
    parameter int KERNEL_LAT = 3,
    parameter int SV_AW      = clog2_min1(NUM_SV * DIM),
    parameter int AL_AW      = clog2_min1(NUM_SV)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              sv_rd_en,
    output logic [SV_AW-1:0]  sv_addr,
    input  logic [DATA_W-1:0] sv_rdata,
    output logic              al_rd_en,
    output logic [AL_AW-1:0]  al_addr,
    input  logic [DATA_W-1:0] al_rdata,
    output logic [DATA_W-1:0] test,
    output logic [DATA_W-1:0] support_vector,
    output logic [DATA_W-1:0] alpha,
    output logic              in_valid,
    output logic              in_start,
    output logic              in_end,
    output logic              vector_start,
    output logic              vector_end,
    input  logic              label,
    input  logic              label_valid,
    output logic              res_label,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
`ifdef SVM_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int EW    = clog2_min1(DIM);
    localparam int SW    = clog2_min1(NUM_SV);
    localparam int BUF_N = 1 << EW;

    localparam logic [EW-1:0]    ELEM_LAST = EW'(DIM - 1);
    localparam logic [SW-1:0]    SV_LAST   = SW'(NUM_SV - 1);
    localparam logic [SV_AW-1:0] ADDR_LAST = SV_AW'(NUM_SV * DIM - 1);

    seq_state_t        state_q, state_d;
    logic [EW-1:0]     ld_idx_q, ld_idx_d;
    logic [EW-1:0]     elem_idx_q, elem_idx_d;
    logic [SW-1:0]     sv_idx_q, sv_idx_d;
    logic [SV_AW-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0] tbuf_q [BUF_N];
    logic [DATA_W-1:0] tbuf_d [BUF_N];
    logic [DATA_W-1:0] test_q, test_d;
    marker_t           mark_q, mark_d;
    logic [DATA_W-1:0] al_hold_q, al_hold_d;
    logic [DATA_W-1:0] alpha_q, alpha_d;
    logic              res_label_q, res_label_d;
    logic              res_valid_q, res_valid_d;

    logic              load_fire;
    logic              issue_last;
    logic              dl_valid;
    logic [DATA_W-1:0] dl_data;

    assign load_fire  = load_valid && (state_q == IDLE);
    assign issue_last = (elem_idx_q == ELEM_LAST) && (sv_idx_q == SV_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load_fire && (ld_idx_q == ELEM_LAST)) state_d = RUN;
            RUN:     if (issue_last)                           state_d = DRAIN;
            DRAIN:   if (label_valid)                          state_d = RESULT;
            RESULT:  if (res_ready)                            state_d = IDLE;
            default:                                           state_d = IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b1;
        sv_rd_en   = 1'b0;
        al_rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                busy       = 1'b0;
            end
            RUN: begin
                sv_rd_en = 1'b1;
                al_rd_en = (elem_idx_q == '0);
            end
            default: ;
        endcase
    end

    // ---------------- counters, buffer, beat markers ----------------
    always_comb begin
        ld_idx_d    = ld_idx_q;
        elem_idx_d  = elem_idx_q;
        sv_idx_d    = sv_idx_q;
        addr_d      = '0;
        tbuf_d      = tbuf_q;
        test_d      = test_q;
        mark_d      = '0;
        res_label_d = res_label_q;
        res_valid_d = res_valid_q;

        if (load_fire) begin
            tbuf_d[ld_idx_q] = load_data;
            ld_idx_d = (ld_idx_q == ELEM_LAST) ? '0 : ld_idx_q + EW'(1);
        end

        if (state_q == RUN) begin
            test_d        = tbuf_q[elem_idx_q];
            mark_d.valid  = 1'b1;
            mark_d.first  = (elem_idx_q == '0) && (sv_idx_q == '0);
            mark_d.last   = issue_last;
            mark_d.vstart = (elem_idx_q == '0);
            mark_d.vend   = (elem_idx_q == ELEM_LAST);
            addr_d        = (addr_q == ADDR_LAST) ? '0 : addr_q + SV_AW'(1);
            if (elem_idx_q == ELEM_LAST) begin
                elem_idx_d = '0;
                sv_idx_d   = (sv_idx_q == SV_LAST) ? '0 : sv_idx_q + SW'(1);
            end else begin
                elem_idx_d = elem_idx_q + EW'(1);
            end
        end

        if ((state_q == DRAIN) && label_valid) begin
            res_label_d = label;
            res_valid_d = 1'b1;
        end else if ((state_q == RESULT) && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_idx_q    <= '0;
            elem_idx_q  <= '0;
            sv_idx_q    <= '0;
            addr_q      <= '0;
            test_q      <= '0;
            mark_q      <= '0;
            res_label_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            ld_idx_q    <= ld_idx_d;
            elem_idx_q  <= elem_idx_d;
            sv_idx_q    <= sv_idx_d;
            addr_q      <= addr_d;
            test_q      <= test_d;
            mark_q      <= mark_d;
            res_label_q <= res_label_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        tbuf_q <= tbuf_d;
    end

    // ---------------- alpha alignment ----------------
    // al_rdata is only valid on the vector_start beat; hold it so a later
    // vector_end beat can push the same SV's alpha into the delay line.
    always_comb begin
        al_hold_d = mark_q.vstart ? al_rdata : al_hold_q;
        alpha_d   = dl_valid ? dl_data : alpha_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_hold_q <= '0;
            alpha_q   <= '0;
        end else begin
            al_hold_q <= al_hold_d;
            alpha_q   <= alpha_d;
        end
    end

    delay_line #(
        .DEPTH (KERNEL_LAT),
        .WIDTH (DATA_W)
    ) u_alpha_dl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (mark_q.vend),
        .in_data   (al_hold_d),
        .out_valid (dl_valid),
        .out_data  (dl_data)
    );

`ifdef SVM_SEQ_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_cnt_d = '0;
        perf_d     = perf_q;
        if ((state_q == RUN) || (state_q == DRAIN)) begin
            perf_cnt_d = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 32'd1;
        end
        if ((state_q == DRAIN) && label_valid) begin
            perf_d = perf_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_q     <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign sv_addr        = addr_q;
    assign al_addr        = AL_AW'(sv_idx_q);
    assign test           = test_q;
    assign support_vector = sv_rdata;
    assign alpha          = dl_valid ? dl_data : alpha_q;
    assign in_valid       = mark_q.valid;
    assign in_start       = mark_q.first;
    assign in_end         = mark_q.last;
    assign vector_start   = mark_q.vstart;
    assign vector_end     = mark_q.vend;
    assign res_label      = res_label_q;
    assign res_valid      = res_valid_q;

endmodule

// File: tb/tb_svm_sequencer.sv
// Self-checking bench for svm_sequencer: a DIM=4/NUM_SV=2 instance and a
// DIM=1/NUM_SV=1 instance, checked against a beat/alpha schedule model.
module tb_svm_sequencer;

    localparam int A_DIM = 4;
    localparam int A_NSV = 2;
    localparam int A_KL  = 3;
    localparam int A_N   = A_DIM * A_NSV;
    localparam int B_KL  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int chk  = 0;
    int pass = 0;

    // ---------------- DUT A signals ----------------
    logic        a_load_valid, a_load_ready;
    logic [31:0] a_load_data;
    logic        a_sv_rd_en, a_al_rd_en;
    logic [2:0]  a_sv_addr;
    logic [0:0]  a_al_addr;
    logic [31:0] a_sv_rdata, a_al_rdata;
    logic [31:0] a_test, a_sv_out, a_alpha;
    logic        a_in_valid, a_in_start, a_in_end, a_vstart, a_vend;
    logic        a_label, a_label_valid, a_res_label, a_res_valid, a_res_ready, a_busy;
    // ---------------- DUT B signals ----------------
    logic        b_load_valid, b_load_ready;
    logic [31:0] b_load_data;
    logic        b_sv_rd_en, b_al_rd_en;
    logic [0:0]  b_sv_addr;
    logic [0:0]  b_al_addr;
    logic [31:0] b_sv_rdata, b_al_rdata;
    logic [31:0] b_test, b_sv_out, b_alpha;
    logic        b_in_valid, b_in_start, b_in_end, b_vstart, b_vend;
    logic        b_label, b_label_valid, b_res_label, b_res_valid, b_res_ready, b_busy;
`ifdef SVM_SEQ_PERF_EN
    logic [31:0] a_perf, b_perf;
`endif

    // Reference memories and test vectors
    logic [31:0] a_sv_mem [A_N];
    logic [31:0] a_al_mem [A_NSV];
    logic [31:0] b_sv_mem [2];
    logic [31:0] b_al_mem [2];
    logic [31:0] vec_a [A_DIM];
    logic [31:0] alpha_prev_a, alpha_prev_b;

    always @(posedge clk) begin
        if (a_sv_rd_en) a_sv_rdata <= a_sv_mem[a_sv_addr];
        if (a_al_rd_en) a_al_rdata <= a_al_mem[a_al_addr];
        if (b_sv_rd_en) b_sv_rdata <= b_sv_mem[b_sv_addr];
        if (b_al_rd_en) b_al_rdata <= b_al_mem[b_al_addr];
    end

    svm_sequencer #(
        .DIM(A_DIM), .NUM_SV(A_NSV), .KERNEL_LAT(A_KL), .SV_AW(3), .AL_AW(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .load_valid(a_load_valid), .load_data(a_load_data), .load_ready(a_load_ready),
        .sv_rd_en(a_sv_rd_en), .sv_addr(a_sv_addr), .sv_rdata(a_sv_rdata),
        .al_rd_en(a_al_rd_en), .al_addr(a_al_addr), .al_rdata(a_al_rdata),
        .test(a_test), .support_vector(a_sv_out), .alpha(a_alpha),
        .in_valid(a_in_valid), .in_start(a_in_start), .in_end(a_in_end),
        .vector_start(a_vstart), .vector_end(a_vend),
        .label(a_label), .label_valid(a_label_valid),
        .res_label(a_res_label), .res_valid(a_res_valid), .res_ready(a_res_ready),
        .busy(a_busy)
`ifdef SVM_SEQ_PERF_EN
        , .perf_cycles(a_perf)
`endif
    );

    svm_sequencer #(
        .DIM(1), .NUM_SV(1), .KERNEL_LAT(B_KL), .SV_AW(1), .AL_AW(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .load_valid(b_load_valid), .load_data(b_load_data), .load_ready(b_load_ready),
        .sv_rd_en(b_sv_rd_en), .sv_addr(b_sv_addr), .sv_rdata(b_sv_rdata),
        .al_rd_en(b_al_rd_en), .al_addr(b_al_addr), .al_rdata(b_al_rdata),
        .test(b_test), .support_vector(b_sv_out), .alpha(b_alpha),
        .in_valid(b_in_valid), .in_start(b_in_start), .in_end(b_in_end),
        .vector_start(b_vstart), .vector_end(b_vend),
        .label(b_label), .label_valid(b_label_valid),
        .res_label(b_res_label), .res_valid(b_res_valid), .res_ready(b_res_ready),
        .busy(b_busy)
`ifdef SVM_SEQ_PERF_EN
        , .perf_cycles(b_perf)
`endif
    );

    // ---------------- helpers driving stimulus ----------------
    task automatic randomize_a_model();
        for (int i = 0; i < A_N; i++)   a_sv_mem[i] = $urandom;
        for (int j = 0; j < A_NSV; j++) a_al_mem[j] = $urandom;
        for (int e = 0; e < A_DIM; e++) vec_a[e]    = $urandom;
    endtask

    // Offers vec_a with random gaps; returns at the negedge of the first RUN cycle.
    task automatic load_a();
        for (int e = 0; e < A_DIM; e++) begin
            a_load_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            chk++;
            if ({a_load_ready, a_busy} !== 2'b10) begin
                $display("FAIL load_ready elem %0d: got ready=%b busy=%b want ready=1 busy=0",
                         e, a_load_ready, a_busy);
            end else pass++;
            a_load_valid = 1'b1;
            a_load_data  = vec_a[e];
            @(negedge clk);
        end
        a_load_valid = 1'b0;
    endtask

    // Checks a full pass cycle by cycle from the first issue cycle (cycle 0).
    task automatic run_pass_a(input int label_at, input logic lbl, input int hold, input bit stray);
        int          stray_c;
        int          b;
        logic        exp_rd;
        logic [4:0]  exp_m;
        logic [31:0] exp_alpha;
        stray_c = stray ? int'($urandom_range(0, A_N - 1)) : -1;
        for (int c = 0; c <= label_at; c++) begin
            exp_rd = (c < A_N);
            chk++;
            if ({a_sv_rd_en, a_al_rd_en} !== {exp_rd, exp_rd && ((c % A_DIM) == 0)} ||
                (exp_rd && (a_sv_addr !== 3'(c)))) begin
                $display("FAIL read_strobe cycle %0d: got sv_rd=%b al_rd=%b addr=%0d want sv_rd=%b al_rd=%b addr=%0d",
                         c, a_sv_rd_en, a_al_rd_en, a_sv_addr, exp_rd,
                         exp_rd && ((c % A_DIM) == 0), c);
            end else pass++;

            b = c - 1;
            exp_m = (c >= 1 && c <= A_N) ?
                    {1'b1, (b == 0), (b == A_N - 1), ((b % A_DIM) == 0), ((b % A_DIM) == A_DIM - 1)} : 5'b0;
            chk++;
            if ({a_in_valid, a_in_start, a_in_end, a_vstart, a_vend} !== exp_m) begin
                $display("FAIL markers cycle %0d: got %b want %b", c,
                         {a_in_valid, a_in_start, a_in_end, a_vstart, a_vend}, exp_m);
            end else pass++;

            if (c >= 1 && c <= A_N) begin
                chk++;
                if (a_test !== vec_a[b % A_DIM] || a_sv_out !== a_sv_mem[b]) begin
                    $display("FAIL beat_data beat %0d: got test=%h sv=%h want test=%h sv=%h",
                             b, a_test, a_sv_out, vec_a[b % A_DIM], a_sv_mem[b]);
                end else pass++;
            end

            // alpha_j becomes visible KERNEL_LAT cycles after SV j's vector_end beat
            exp_alpha = alpha_prev_a;
            for (int j = 0; j < A_NSV; j++) begin
                if (c >= (j + 1) * A_DIM + A_KL) exp_alpha = a_al_mem[j];
            end
            chk++;
            if (a_alpha !== exp_alpha) begin
                $display("FAIL alpha cycle %0d: got %h want %h", c, a_alpha, exp_alpha);
            end else pass++;

            chk++;
            if ({a_res_valid, a_busy, a_load_ready} !== 3'b010) begin
                $display("FAIL busy_state cycle %0d: got res_valid=%b busy=%b load_ready=%b want 0 1 0",
                         c, a_res_valid, a_busy, a_load_ready);
            end else pass++;

            a_load_valid  = (c < label_at) ? 1'($urandom) : 1'b0;
            a_load_data   = $urandom;
            a_label_valid = 1'b0;
            a_label       = 1'($urandom);
            if (c == label_at) begin
                a_label_valid = 1'b1;
                a_label       = lbl;
            end else if (c == stray_c) begin
                a_label_valid = 1'b1;
                a_label       = ~lbl;
            end
            @(negedge clk);
        end
        a_label_valid = 1'b0;
        a_load_valid  = 1'b0;

        for (int h = 0; h < hold; h++) begin
            chk++;
            if ({a_res_valid, a_res_label, a_busy, a_load_ready} !== {1'b1, lbl, 1'b1, 1'b0}) begin
                $display("FAIL result_hold cycle %0d: got valid=%b label=%b busy=%b ready=%b want 1 %b 1 0",
                         h, a_res_valid, a_res_label, a_busy, a_load_ready, lbl);
            end else pass++;
`ifdef SVM_SEQ_PERF_EN
            if (h == 0) begin
                chk++;
                if (a_perf !== 32'(label_at + 1)) begin
                    $display("FAIL perf_cycles: got %0d want %0d", a_perf, label_at + 1);
                end else pass++;
            end
`endif
            a_res_ready = (h == hold - 1);
            @(negedge clk);
        end
        a_res_ready  = 1'b0;
        alpha_prev_a = a_al_mem[A_NSV - 1];
        chk++;
        if ({a_res_valid, a_busy, a_load_ready} !== 3'b001 || a_alpha !== alpha_prev_a) begin
            $display("FAIL result_release: got valid=%b busy=%b ready=%b alpha=%h want 0 0 1 alpha=%h",
                     a_res_valid, a_busy, a_load_ready, a_alpha, alpha_prev_a);
        end else pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        a_load_valid = 0; a_load_data = 0; a_label = 0; a_label_valid = 0; a_res_ready = 0;
        b_load_valid = 0; b_load_data = 0; b_label = 0; b_label_valid = 0; b_res_ready = 0;
        repeat (2) @(negedge clk);
        chk++;
        if ({a_in_valid, a_in_start, a_in_end, a_vstart, a_vend, a_sv_rd_en, a_al_rd_en,
             a_busy, a_res_valid, a_res_label, a_load_ready} !== 11'b00000000001 ||
            a_test !== 32'd0 || a_alpha !== 32'd0) begin
            $display("FAIL reset_a: got markers=%b test=%h alpha=%h busy=%b ready=%b",
                     {a_in_valid, a_in_start, a_in_end, a_vstart, a_vend}, a_test, a_alpha,
                     a_busy, a_load_ready);
        end else pass++;
        chk++;
        if ({b_in_valid, b_in_start, b_in_end, b_vstart, b_vend, b_sv_rd_en, b_al_rd_en,
             b_busy, b_res_valid, b_res_label, b_load_ready} !== 11'b00000000001 ||
            b_test !== 32'd0 || b_alpha !== 32'd0) begin
            $display("FAIL reset_b: got markers=%b test=%h alpha=%h busy=%b ready=%b",
                     {b_in_valid, b_in_start, b_in_end, b_vstart, b_vend}, b_test, b_alpha,
                     b_busy, b_load_ready);
        end else pass++;
`ifdef SVM_SEQ_PERF_EN
        chk++;
        if (a_perf !== 32'd0) begin
            $display("FAIL reset_perf: got %0d want 0", a_perf);
        end else pass++;
`endif
        rst_n = 1'b1;
        alpha_prev_a = 32'd0;
        alpha_prev_b = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_first_pass();
        randomize_a_model();
        for (int e = 0; e < A_DIM; e++) vec_a[e] = 32'(e + 1);
        a_al_mem[0] = 32'sd5;
        a_al_mem[1] = -32'sd3;
        load_a();
        run_pass_a(A_N + 6, 1'b1, 5, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) begin
            randomize_a_model();
            load_a();
            run_pass_a(A_N + A_KL + int'($urandom_range(0, 5)), 1'($urandom),
                       int'($urandom_range(1, 3)), 1'b1);
        end
    endtask

    task automatic test_dim1();
        logic        lbl;
        logic [31:0] v;
        v           = $urandom;
        b_sv_mem[0] = $urandom;
        b_al_mem[0] = $urandom;
        lbl         = 1'($urandom);
        chk++;
        if ({b_load_ready, b_busy} !== 2'b10) begin
            $display("FAIL dim1_idle: got ready=%b busy=%b want 1 0", b_load_ready, b_busy);
        end else pass++;
        b_load_valid = 1'b1;
        b_load_data  = v;
        @(negedge clk);
        b_load_valid = 1'b0;
        chk++;
        if ({b_sv_rd_en, b_al_rd_en, b_load_ready, b_busy} !== 4'b1101 || b_sv_addr !== 1'b0 ||
            {b_in_valid, b_in_start, b_in_end, b_vstart, b_vend} !== 5'b0) begin
            $display("FAIL dim1_issue: got rd=%b al=%b ready=%b busy=%b addr=%0d want 1 1 0 1 addr=0",
                     b_sv_rd_en, b_al_rd_en, b_load_ready, b_busy, b_sv_addr);
        end else pass++;
        b_label_valid = 1'b1;
        b_label       = ~lbl;
        @(negedge clk);
        b_label_valid = 1'b0;
        chk++;
        if ({b_in_valid, b_in_start, b_in_end, b_vstart, b_vend, b_sv_rd_en} !== 6'b111110 ||
            b_test !== v || b_sv_out !== b_sv_mem[0]) begin
            $display("FAIL dim1_beat: got markers=%b rd=%b test=%h sv=%h want 11111 0 test=%h sv=%h",
                     {b_in_valid, b_in_start, b_in_end, b_vstart, b_vend}, b_sv_rd_en,
                     b_test, b_sv_out, v, b_sv_mem[0]);
        end else pass++;
        chk++;
        if (b_res_valid !== 1'b0 || b_alpha !== alpha_prev_b) begin
            $display("FAIL dim1_stray_label: got res_valid=%b alpha=%h want 0 alpha=%h",
                     b_res_valid, b_alpha, alpha_prev_b);
        end else pass++;
        @(negedge clk);
        chk++;
        if ({b_in_valid, b_vend, b_res_valid} !== 3'b000 || b_alpha !== alpha_prev_b) begin
            $display("FAIL dim1_early_alpha: got valid=%b vend=%b res=%b alpha=%h want 0 0 0 alpha=%h",
                     b_in_valid, b_vend, b_res_valid, b_alpha, alpha_prev_b);
        end else pass++;
        @(negedge clk);
        chk++;
        if (b_alpha !== b_al_mem[0]) begin
            $display("FAIL dim1_alpha: got %h want %h", b_alpha, b_al_mem[0]);
        end else pass++;
        b_label_valid = 1'b1;
        b_label       = lbl;
        @(negedge clk);
        b_label_valid = 1'b0;
        chk++;
        if ({b_res_valid, b_res_label, b_busy} !== {1'b1, lbl, 1'b1}) begin
            $display("FAIL dim1_result: got valid=%b label=%b busy=%b want 1 %b 1",
                     b_res_valid, b_res_label, b_busy, lbl);
        end else pass++;
`ifdef SVM_SEQ_PERF_EN
        chk++;
        if (b_perf !== 32'd4) begin
            $display("FAIL dim1_perf: got %0d want 4", b_perf);
        end else pass++;
`endif
        b_res_ready = 1'b1;
        @(negedge clk);
        b_res_ready  = 1'b0;
        alpha_prev_b = b_al_mem[0];
        chk++;
        if ({b_res_valid, b_busy, b_load_ready} !== 3'b001 || b_alpha !== alpha_prev_b) begin
            $display("FAIL dim1_release: got valid=%b busy=%b ready=%b alpha=%h want 0 0 1 alpha=%h",
                     b_res_valid, b_busy, b_load_ready, b_alpha, alpha_prev_b);
        end else pass++;
    endtask

    task automatic test_reset_mid_run();
        randomize_a_model();
        load_a();
        repeat (6) @(negedge clk);
        chk++;
        if ({a_in_valid, a_sv_rd_en} !== 2'b11 || a_sv_addr !== 3'd6) begin
            $display("FAIL pre_reset_run: got valid=%b rd=%b addr=%0d want 1 1 addr=6",
                     a_in_valid, a_sv_rd_en, a_sv_addr);
        end else pass++;
        rst_n = 1'b0;
        #1;
        chk++;
        if ({a_in_valid, a_in_start, a_in_end, a_vstart, a_vend, a_sv_rd_en, a_al_rd_en,
             a_busy, a_res_valid} !== 9'b0 || a_alpha !== 32'd0 || a_test !== 32'd0) begin
            $display("FAIL reset_mid_run: got markers=%b rd=%b busy=%b alpha=%h test=%h want all 0",
                     {a_in_valid, a_in_start, a_in_end, a_vstart, a_vend}, a_sv_rd_en,
                     a_busy, a_alpha, a_test);
        end else pass++;
        @(negedge clk);
        rst_n = 1'b1;
        alpha_prev_a = 32'd0;
        alpha_prev_b = 32'd0;
        @(negedge clk);
        chk++;
        if ({a_busy, a_load_ready} !== 2'b01) begin
            $display("FAIL post_reset_idle: got busy=%b ready=%b want 0 1", a_busy, a_load_ready);
        end else pass++;
        randomize_a_model();
        load_a();
        run_pass_a(A_N + A_KL + 2, 1'($urandom), 2, 1'b1);
    endtask

    initial begin
        test_reset();
        test_first_pass();
        test_back_to_back();
        test_dim1();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

// File: doc/svm_sequencer.md
Name: svm_sequencer

Overview:
- Controller that drives one classification pass through the test_sum datapath.
- Captures a DIM-element test vector from an input stream into a local buffer.
- Then walks NUM_SV support vectors in support-vector memory and alpha memory, both external and synchronous-read.
- Emits the element stream with start/end markers, aligns alpha with the kernel output latency, and returns the resulting label over a valid/ready handshake.

Parameters:
- DIM, 8, elements per vector (>=1)
- NUM_SV, 16, support vectors per model (>=1)
- KERNEL_LAT, 3, cycles from vector_end issued to kernel k_valid (>=1)
- SV_AW, $clog2(NUM_SV*DIM), support-vector memory address width
- AL_AW, $clog2(NUM_SV), alpha memory address width

Ports:
- clk  in  1  clock, single domain
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  test element offered
- load_data  in  32  signed test element
- load_ready  out  1  high only in IDLE
- sv_rd_en  out  1  support-vector memory read strobe
- sv_addr  out  SV_AW  sv_idx*DIM + elem_idx
- sv_rdata  in  32  read data, valid 1 cycle after sv_rd_en
- al_rd_en  out  1  alpha memory read strobe
- al_addr  out  AL_AW  sv_idx
- al_rdata  in  32  read data, valid 1 cycle after al_rd_en
- test  out  32  test element to datapath
- support_vector  out  32  = sv_rdata (combinational pass-through)
- alpha  out  32  kernel-aligned alpha
- in_valid, in_start, in_end, vector_start, vector_end  out  1 each  datapath markers
- label  in  1  datapath label
- label_valid  in  1  datapath label pulse
- res_label  out  1  captured label
- res_valid  out  1  result held
- res_ready  in  1  result consumed
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low) values:
  - FSM = IDLE; all counters 0.
  - test, alpha, res_label = 0; every strobe and marker = 0.
  - Test buffer contents are don't-care.
- States: IDLE, RUN, DRAIN, RESULT.
- IDLE:
  - load_ready=1; each load_valid writes buf[ld_idx] and increments ld_idx.
  - On the DIM-th accept: ld_idx clears, go to RUN.
- RUN, one element issued per cycle with no bubbles:
  - sv_rd_en=1, sv_addr = sv_idx*DIM+elem_idx.
  - al_rd_en=1 only when elem_idx==0.
  - elem_idx wraps at DIM-1 and sv_idx then increments.
  - After element (NUM_SV-1, DIM-1) is issued, go to DRAIN.
- Issue-to-output latency is exactly 1 cycle. The cycle after each issue:
  - in_valid=1; test = buf[elem_idx] (registered).
  - vector_start on elem 0; vector_end on elem DIM-1.
  - in_start on the first element of SV 0; in_end on the last element of SV NUM_SV-1.
  - When DIM==1 or NUM_SV==1, multiple markers coincide on one beat.
- Alpha alignment:
  - al_rdata is captured into a KERNEL_LAT-deep delay line tagged with the vector_end beat.
  - alpha updates to alpha_j exactly KERNEL_LAT cycles after SV j's vector_end output beat, then holds until the next update.
- DRAIN:
  - No reads; wait for label_valid.
  - On label_valid: res_label = label, res_valid = 1, go to RESULT.
- RESULT:
  - res_valid held until res_valid&res_ready, then clears; go to IDLE.
- label_valid outside DRAIN is ignored.
- load_valid outside IDLE is not accepted.
- Reset mid-pass aborts at once; datapath markers drop the same instant.
- Address arithmetic is unsigned and never wraps within a pass; sv_addr maximum = NUM_SV*DIM-1.

Optional Feature:
- SVM_SEQ_PERF_EN defined:
  - Adds output perf_cycles[31:0], a saturating count of cycles from entering RUN to res_valid rising.
  - Latched when res_valid rises; reset 0.
- Undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Package svm_pkg holds:
  - seq_state_t enum {IDLE,RUN,DRAIN,RESULT}
  - localparam DATA_W=32
  - a typedef for the marker bundle (valid,start,end,vstart,vend)
- One sub-module, delay_line: parameterised depth/width shift register with valid, used for the alpha alignment.

Test Plan:
- DIM=4, NUM_SV=2: load 1,2,3,4 -> load_ready drops after 4th accept; busy=1; 8 consecutive in_valid beats; sv_addr 0..7; vector_start at beats 0,4; vector_end at 3,7; in_start beat 0 only; in_end beat 7 only.
- Alpha memory {5,-3}, KERNEL_LAT=3 -> alpha=5 exactly 3 cycles after beat 3, alpha=-3 exactly 3 cycles after beat 7; al_rd_en pulses only at issue of elem 0.
- label_valid=1 with label=1 in DRAIN while res_ready=0 for 5 cycles -> res_valid held, res_label=1; res_ready=1 -> res_valid clears next cycle, FSM IDLE, load_ready=1.
- DIM=1, NUM_SV=1 -> single beat carrying in_start, in_end, vector_start, vector_end together; stray label_valid injected during RUN ignored.
- rst_n pulsed low mid-RUN (sv_idx=1, elem_idx=2) -> all markers 0 immediately; after release busy=0, fresh 4-element load runs a full pass from sv_addr 0.
- With SVM_SEQ_PERF_EN, DIM=4, NUM_SV=2, datapath label returned 6 cycles after last beat -> perf_cycles = 8+1+6 = 15.
